ifu_fetch_ctrl: RTL and testbench
=================================

Name: ifu_fetch_ctrl

Overview:
Multi-cycle fetch/execute sequencer for the single-cycle core, placed between the pc register, decode_exec and an instruction memory with a valid/ready request port and a variable-latency response port.
It issues one fetch per instruction, holds the returned word, and presents it to decode_exec for exactly one execute cycle.
In that cycle it enables the pc write, so the pc advances only once per completed instruction.
It also stops the core on ebreak, on a memory error, on a timeout or on a misaligned pc, and counts retired instructions.

Parameters:
TIMEOUT, 16, max cycles spent in WAIT before declaring a fault (>=2)
CNT_W, 32, width of the retired-instruction counter

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
cur_pc  in  32  current pc from the pc register
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  32  fetch address
imem_rsp_valid  in  1  response data valid
imem_rsp_data  in  32  fetched instruction word
imem_rsp_err  in  1  response carries a bus error
ebreak  in  1  decode_exec flags current inst as ebreak (valid only while inst_valid)
inst  out  32  latched instruction to decode_exec
inst_valid  out  1  inst is being executed this cycle
pc_wen  out  1  write enable for pc register (load dnpc)
halted  out  1  core stopped (ebreak or fault)
fault  out  1  core stopped due to error/timeout/misalignment
instret  out  CNT_W  retired-instruction count

Behaviour:
- All state changes on posedge clk. rst is synchronous, active-high, and has priority over everything else.
- Reset values: state=IDLE; inst=0; instret=0; timeout counter=0; all 1-bit outputs 0; imem_req_addr=0.
- States: IDLE, REQ, WAIT, EXEC, HALT, FAULT. Outputs are decoded from state plus registers; only pc_wen depends combinationally on ebreak.
- IDLE: all outputs inactive. Goes to REQ on the first cycle with rst=0.
- REQ:
  - If cur_pc[1:0]!=0: go to FAULT next cycle; imem_req_valid stays 0.
  - Otherwise imem_req_valid=1 and imem_req_addr=cur_pc. Both are held stable until imem_req_ready.
  - On valid&&ready: go to WAIT and clear the timeout counter.
  - imem_rsp_valid is ignored in REQ.
- WAIT:
  - Counter increments every cycle.
  - If imem_rsp_valid: latch imem_rsp_data into inst. Go to FAULT if imem_rsp_err=1, else to EXEC.
  - Else if counter==TIMEOUT-1: go to FAULT.
  - A response arriving in the same cycle the counter hits TIMEOUT-1 wins; it is not a timeout.
  - Minimum latency: request accepted in cycle n, response in cycle n+1, EXEC in cycle n+2.
- EXEC (exactly one cycle):
  - inst_valid=1 and instret increments by 1 (ebreak counts).
  - If ebreak=0: pc_wen=1, next state REQ.
  - If ebreak=1: pc_wen=0, next state HALT, so the pc stays on the ebreak.
  - The request for the next fetch uses the updated cur_pc in the following REQ cycle.
- HALT: halted=1, fault=0. Terminal until rst.
- FAULT: halted=1, fault=1. Terminal until rst. On a memory error, inst holds the erroneous word for debug.
- instret wraps modulo 2^CNT_W with no flag.
- pc_wen is never asserted outside EXEC, and at most once per fetch.
- Reset mid-REQ/WAIT/EXEC: the sequencer returns to IDLE on the next edge and abandons any outstanding fetch.
  - The memory model must be reset by the same rst.
  - An imem_rsp_valid arriving in IDLE or REQ is ignored.

Test Plan:
- Ready always 1, 1-cycle response, words 0x00000013 x3 then ebreak 0x00100073 -> four EXEC cycles, pc_wen pulses 3 times, halted=1, fault=0, instret=4, pc remains at the ebreak address.
- Ready held low 5 cycles at pc=0x80000000 -> imem_req_valid=1 with addr stable 0x80000000 for all 5 cycles; WAIT entered only after ready rises.
- Response delayed TIMEOUT-1 cycles vs. never arriving (TIMEOUT=16) -> first case executes normally; second enters FAULT exactly 16 cycles after WAIT entry, fault=1, no pc_wen.
- imem_rsp_err=1 with data 0xDEADBEEF -> FAULT, inst=0xDEADBEEF, inst_valid never asserted, instret unchanged.
- cur_pc=0x80000002 on entering REQ -> imem_req_valid never asserted, FAULT next cycle.
- rst asserted for one cycle while in WAIT -> IDLE, instret=0, inst=0; a stale rsp_valid pulse during IDLE/REQ is ignored; the next fetch completes normally.

Source files
------------

// File: rtl/ifu_fetch_ctrl.sv
// Fetch/execute sequencer: one memory fetch per instruction, one execute cycle,
// one pc write per retired instruction. Stops on ebreak, bus error, timeout or misaligned pc.
//
// state | meaning
// IDLE  | out of reset, nothing outstanding
// REQ   | fetch request presented at cur_pc, waiting for imem_req_ready
// WAIT  | request accepted, waiting for imem_rsp_valid (bounded by TIMEOUT)
// EXEC  | latched word presented to decode_exec for one cycle, pc written unless ebreak
// HALT  | stopped on ebreak, terminal until rst
// FAULT | stopped on bus error, timeout or misaligned pc, terminal until rst
module ifu_fetch_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      cur_pc,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [31:0]      imem_req_addr,
  input  logic             imem_rsp_valid,
  input  logic [31:0]      imem_rsp_data,
  input  logic             imem_rsp_err,
  input  logic             ebreak,
  output logic [31:0]      inst,
  output logic             inst_valid,
  output logic             pc_wen,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] instret
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_EXEC  = 3'd3,
    S_HALT  = 3'd4,
    S_FAULT = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      inst_q, inst_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic             pc_aligned;

  assign pc_aligned = (cur_pc[1:0] == 2'b00);

  always_comb begin
    state_d        = state_q;
    inst_d         = inst_q;
    instret_d      = instret_q;
    tmo_d          = tmo_q;
    imem_req_valid = 1'b0;
    imem_req_addr  = 32'h0;
    inst_valid     = 1'b0;
    pc_wen         = 1'b0;
    halted         = 1'b0;
    fault          = 1'b0;

    unique case (state_q)
      S_IDLE: state_d = S_REQ;

      S_REQ: begin
        // cur_pc cannot move while in REQ, so address stays stable until accepted
        if (!pc_aligned) begin
          state_d = S_FAULT;
        end else begin
          imem_req_valid = 1'b1;
          imem_req_addr  = cur_pc;
          if (imem_req_ready) begin
            state_d = S_WAIT;
            tmo_d   = '0;
          end
        end
      end

      S_WAIT: begin
        tmo_d = tmo_q + TW'(1);
        // a response in the last allowed cycle still wins over the timeout
        if (imem_rsp_valid) begin
          inst_d  = imem_rsp_data;
          state_d = imem_rsp_err ? S_FAULT : S_EXEC;
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_FAULT;
        end
      end

      S_EXEC: begin
        inst_valid = 1'b1;
        instret_d  = instret_q + CNT_W'(1);
        if (ebreak) begin
          state_d = S_HALT;
        end else begin
          pc_wen  = 1'b1;
          state_d = S_REQ;
        end
      end

      S_HALT: halted = 1'b1;

      S_FAULT: begin
        halted = 1'b1;
        fault  = 1'b1;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      inst_q    <= 32'h0;
      instret_q <= '0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      inst_q    <= inst_d;
      instret_q <= instret_d;
      tmo_q     <= tmo_d;
    end
  end

  assign inst    = inst_q;
  assign instret = instret_q;

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Directed bench for ifu_fetch_ctrl: a per-cycle vector table for a straight-line
// program ending in ebreak, then hand-written sequences for stalls, timeout, errors and reset.
module tb_ifu_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] cur_pc = 32'h8000_0000;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        imem_rsp_err = 1'b0;
  logic        ebreak = 1'b0;
  logic [31:0] inst;
  logic        inst_valid;
  logic        pc_wen;
  logic        halted;
  logic        fault;
  logic [31:0] instret;

  int total = 0;
  int bad   = 0;

  ifu_fetch_ctrl #(.TIMEOUT(16), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .cur_pc(cur_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .imem_rsp_err(imem_rsp_err),
    .ebreak(ebreak), .inst(inst), .inst_valid(inst_valid), .pc_wen(pc_wen),
    .halted(halted), .fault(fault), .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [31:0] pc;
    logic        rdy;
    logic        rv;
    logic [31:0] rd;
    logic        re;
    logic        eb;
    logic        e_rv;
    logic [31:0] e_addr;
    logic        e_iv;
    logic        e_wen;
    logic        e_h;
    logic        e_f;
    logic [31:0] e_inst;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Inputs change just after the falling edge; outputs are sampled 1 time unit later.
  task automatic drive(input logic r, input logic [31:0] pc, input logic rdy, input logic rv,
                       input logic [31:0] rd, input logic re, input logic eb);
    @(negedge clk);
    rst = r; cur_pc = pc; imem_req_ready = rdy; imem_rsp_valid = rv;
    imem_rsp_data = rd; imem_rsp_err = re; ebreak = eb;
    #1;
  endtask

  task automatic idle_after_reset(input logic [31:0] pc);
    drive(1'b1, pc, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    drive(1'b0, pc, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("idle_req_valid", {31'h0, imem_req_valid}, 32'h0);
    chk("idle_halted", {31'h0, halted}, 32'h0);
  endtask

  initial begin
    // rst rdy rv rd re eb | req_valid addr iv wen halted fault inst instret
    tbl[0]  = '{1'b1, 32'h8000_0000, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         32'd0};
    tbl[1]  = '{1'b0, 32'h8000_0000, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         32'd0};
    tbl[2]  = '{1'b0, 32'h8000_0000, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         32'd0};
    tbl[3]  = '{1'b0, 32'h8000_0000, 1'b1, 1'b1, 32'h0000_0013, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         32'd0};
    tbl[4]  = '{1'b0, 32'h8000_0000, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0013, 32'd0};
    tbl[5]  = '{1'b0, 32'h8000_0004, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 32'h8000_0004, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0013, 32'd1};
    tbl[6]  = '{1'b0, 32'h8000_0004, 1'b1, 1'b1, 32'h0000_0013, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0013, 32'd1};
    tbl[7]  = '{1'b0, 32'h8000_0004, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0013, 32'd1};
    tbl[8]  = '{1'b0, 32'h8000_0008, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 32'h8000_0008, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0013, 32'd2};
    tbl[9]  = '{1'b0, 32'h8000_0008, 1'b1, 1'b1, 32'h0000_0013, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0013, 32'd2};
    tbl[10] = '{1'b0, 32'h8000_0008, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0013, 32'd2};
    tbl[11] = '{1'b0, 32'h8000_000C, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 32'h8000_000C, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0013, 32'd3};
    tbl[12] = '{1'b0, 32'h8000_000C, 1'b1, 1'b1, 32'h0010_0073, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0013, 32'd3};
    tbl[13] = '{1'b0, 32'h8000_000C, 1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b0, 32'h0010_0073, 32'd3};
    tbl[14] = '{1'b0, 32'h8000_000C, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 1'b0, 32'h0010_0073, 32'd4};
    tbl[15] = '{1'b0, 32'h8000_000C, 1'b1, 1'b1, 32'h0000_0013, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 1'b0, 32'h0010_0073, 32'd4};

    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].rst, tbl[i].pc, tbl[i].rdy, tbl[i].rv, tbl[i].rd, tbl[i].re, tbl[i].eb);
      chk($sformatf("tbl%0d_req_valid", i), {31'h0, imem_req_valid}, {31'h0, tbl[i].e_rv});
      if (tbl[i].e_rv || tbl[i].rst)
        chk($sformatf("tbl%0d_req_addr", i), imem_req_addr, tbl[i].e_addr);
      chk($sformatf("tbl%0d_inst_valid", i), {31'h0, inst_valid}, {31'h0, tbl[i].e_iv});
      chk($sformatf("tbl%0d_pc_wen", i), {31'h0, pc_wen}, {31'h0, tbl[i].e_wen});
      chk($sformatf("tbl%0d_halted", i), {31'h0, halted}, {31'h0, tbl[i].e_h});
      chk($sformatf("tbl%0d_fault", i), {31'h0, fault}, {31'h0, tbl[i].e_f});
      chk($sformatf("tbl%0d_inst", i), inst, tbl[i].e_inst);
      chk($sformatf("tbl%0d_instret", i), instret, tbl[i].e_cnt);
    end

    // Ready held low for 5 cycles: request and address must stay put
    idle_after_reset(32'h8000_0000);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 32'h8000_0000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      chk("stall_req_valid", {31'h0, imem_req_valid}, 32'h1);
      chk("stall_req_addr", imem_req_addr, 32'h8000_0000);
    end
    drive(1'b0, 32'h8000_0000, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("stall_accept_valid", {31'h0, imem_req_valid}, 32'h1);
    drive(1'b0, 32'h8000_0000, 1'b0, 1'b1, 32'h0000_0093, 1'b0, 1'b0);
    chk("stall_wait_req_valid", {31'h0, imem_req_valid}, 32'h0);
    drive(1'b0, 32'h8000_0000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("stall_exec_iv", {31'h0, inst_valid}, 32'h1);
    chk("stall_exec_inst", inst, 32'h0000_0093);

    // Response in the last allowed WAIT cycle still executes
    idle_after_reset(32'h8000_0000);
    drive(1'b0, 32'h8000_0000, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) begin
      drive(1'b0, 32'h8000_0000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      chk("late_wait_fault", {31'h0, fault}, 32'h0);
    end
    drive(1'b0, 32'h8000_0000, 1'b0, 1'b1, 32'h0000_0013, 1'b0, 1'b0);
    chk("late_last_fault", {31'h0, fault}, 32'h0);
    drive(1'b0, 32'h8000_0000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("late_exec_iv", {31'h0, inst_valid}, 32'h1);
    chk("late_exec_wen", {31'h0, pc_wen}, 32'h1);
    chk("late_exec_fault", {31'h0, fault}, 32'h0);

    // No response at all: FAULT exactly 16 cycles after WAIT entry
    idle_after_reset(32'h8000_0000);
    drive(1'b0, 32'h8000_0000, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 32'h8000_0000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      chk("tmo_wait_fault", {31'h0, fault}, 32'h0);
      chk("tmo_wait_wen", {31'h0, pc_wen}, 32'h0);
    end
    drive(1'b0, 32'h8000_0000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("tmo_fault", {31'h0, fault}, 32'h1);
    chk("tmo_halted", {31'h0, halted}, 32'h1);
    chk("tmo_wen", {31'h0, pc_wen}, 32'h0);
    chk("tmo_instret", instret, 32'd0);

    // Bus error: FAULT with the bad word kept, never executed
    idle_after_reset(32'h8000_0000);
    drive(1'b0, 32'h8000_0000, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    drive(1'b0, 32'h8000_0000, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 32'h8000_0000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      chk("err_fault", {31'h0, fault}, 32'h1);
      chk("err_iv", {31'h0, inst_valid}, 32'h0);
      chk("err_inst", inst, 32'hDEAD_BEEF);
      chk("err_instret", instret, 32'd0);
    end

    // Misaligned pc: no request, FAULT next cycle
    idle_after_reset(32'h8000_0002);
    drive(1'b0, 32'h8000_0002, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("mis_req_valid", {31'h0, imem_req_valid}, 32'h0);
    chk("mis_fault_early", {31'h0, fault}, 32'h0);
    drive(1'b0, 32'h8000_0002, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("mis_fault", {31'h0, fault}, 32'h1);
    chk("mis_req_valid2", {31'h0, imem_req_valid}, 32'h0);

    // Reset while in WAIT, stale responses in IDLE/REQ ignored, then a clean fetch
    idle_after_reset(32'h8000_0000);
    drive(1'b0, 32'h8000_0000, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    drive(1'b0, 32'h8000_0000, 1'b0, 1'b1, 32'h0000_0013, 1'b0, 1'b0);
    drive(1'b0, 32'h8000_0000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    drive(1'b0, 32'h8000_0004, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("rstw_instret_pre", instret, 32'd1);
    drive(1'b1, 32'h8000_0004, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    drive(1'b0, 32'h8000_0004, 1'b0, 1'b1, 32'h0000_0BAD, 1'b0, 1'b0);
    chk("rstw_idle_instret", instret, 32'd0);
    chk("rstw_idle_inst", inst, 32'h0);
    chk("rstw_idle_req", {31'h0, imem_req_valid}, 32'h0);
    drive(1'b0, 32'h8000_0004, 1'b0, 1'b1, 32'h0000_0BAD, 1'b0, 1'b0);
    chk("rstw_req_valid", {31'h0, imem_req_valid}, 32'h1);
    drive(1'b0, 32'h8000_0004, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("rstw_req_still", {31'h0, imem_req_valid}, 32'h1);
    chk("rstw_req_inst", inst, 32'h0);
    drive(1'b0, 32'h8000_0004, 1'b0, 1'b1, 32'h0000_0033, 1'b0, 1'b0);
    chk("rstw_wait_inst", inst, 32'h0);
    chk("rstw_wait_iv", {31'h0, inst_valid}, 32'h0);
    drive(1'b0, 32'h8000_0004, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("rstw_exec_iv", {31'h0, inst_valid}, 32'h1);
    chk("rstw_exec_inst", inst, 32'h0000_0033);
    chk("rstw_exec_wen", {31'h0, pc_wen}, 32'h1);
    drive(1'b0, 32'h8000_0008, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("rstw_instret_post", instret, 32'd1);
    chk("rstw_next_req", {31'h0, imem_req_valid}, 32'h1);
    chk("rstw_next_addr", imem_req_addr, 32'h8000_0008);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
